// File: rtl/rca_seq_adder_ctrl.sv
// rca_seq_adder_ctrl: sequential WIDTH-bit adder built from a single 4-bit
// ripple-carry slice. The slice is reused once per cycle, least-significant
// nibble first, with the carry held in a register between cycles.
// Handshake: in_valid/in_ready to accept an operation, out_valid/out_ready
// to deliver the result. The FSM runs IDLE -> RUN (NSLICE cycles) -> DONE.
module rca_seq_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy
);

    // Number of 4-bit slices per operation and the width of the slice index.
    localparam int NSLICE = WIDTH / 4;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q,     state_d;
    logic [KW-1:0]     k_q,         k_d;
    logic              carry_q,     carry_d;
    logic [WIDTH-1:0]  sum_q,       sum_d;
    logic              c_out_q,     c_out_d;
    logic              in_ready_q,  in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q,      busy_d;

    // Captured operands; pure data, only loaded on acceptance.
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;

    logic              accept;
    logic [3:0]        slice_a;
    logic [3:0]        slice_b;
    logic [4:0]        slice_res;

    // 4-bit ripple-carry adder: four full adders chained through the carry.
    // Returns {carry_out, sum[3:0]}.
    function automatic logic [4:0] rca4(input logic [3:0] x,
                                        input logic [3:0] y,
                                        input logic       ci);
        logic [3:0] s;
        logic       c;
        c = ci;
        for (int i = 0; i < 4; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {c, s};
    endfunction

    // Acceptance only happens from IDLE; inputs are ignored in every other state.
    assign accept    = (state_q == ST_IDLE) && in_valid;

    // The single shared slice, fed by the nibble selected by the slice index.
    assign slice_a   = a_q[4*k_q +: 4];
    assign slice_b   = b_q[4*k_q +: 4];
    assign slice_res = rca4(slice_a, slice_b, carry_q);

    // Next-state, datapath update and registered-output decode.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_RUN;
                    k_d     = '0;
                    carry_d = c_in;
                end
            end
            ST_RUN: begin
                sum_d[4*k_q +: 4] = slice_res[3:0];
                carry_d           = slice_res[4];
                if (k_q == K_LAST) begin
                    state_d = ST_DONE;
                    c_out_d = slice_res[4];
                    k_d     = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ST_DONE: begin
                // Result is held until the consumer takes it; no new
                // acceptance is possible on the edge that leaves DONE.
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake outputs are registered, decoded from the next state so
        // they line up exactly with the state register.
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
    end

    // FSM, slice index, carry, result and handshake registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            c_out_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            carry_q     <= carry_d;
            sum_q       <= sum_d;
            c_out_q     <= c_out_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Operand capture on acceptance; later changes on a/b are not seen.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= a;
            b_q <= b;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign c_out     = c_out_q;

endmodule
